// File: rtl/rom_fetch_if.sv
// ---------------------------------------------------------------------------
// rom_fetch_if
//   Instruction stream handshake between the ROM fetch unit (producer) and
//   the instruction consumer (decoder/executor).
//
//   instr_valid  producer -> consumer  buffer head holds a word
//   instr_ready  consumer -> producer  consumer takes the head this cycle
//   instr_data   producer -> consumer  head word (WIDTH+1 bits)
//   instr_pc     producer -> consumer  ROM address the head word came from
//
//   modport master : the fetch unit
//   modport slave  : the consumer
// ---------------------------------------------------------------------------
interface rom_fetch_if #(
    parameter int WIDTH = 15,
    parameter int AW    = 11
);
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH:0]   instr_data;
    logic [AW-1:0]    instr_pc;

    modport master (
        output instr_valid,
        output instr_data,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_data,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/rom_fetch.sv
// ---------------------------------------------------------------------------
// rom_fetch
//   Sequential reader for a ROM with a 1-cycle registered read. Walks the
//   ROM from address 0, absorbs the read latency with an in-flight slot and
//   a small output FIFO, and streams {pc, word} pairs downstream through a
//   valid/ready handshake. A jump pulse flushes everything and restarts the
//   walk at a new address; the walk stops after address DEPTH (no wrap).
//
//   Parameters
//     WIDTH       MSB index of a ROM word (word is WIDTH+1 bits)
//     DEPTH       highest valid ROM address
//     FIFO_DEPTH  output buffer entries (>=2; 2 sustains one word/cycle)
//
//   Ports
//     clk         clock, all state on posedge
//     rst         synchronous reset, active high
//     rom_addr    address to the ROM, taken straight from the pc register
//     rom_data    ROM read data, valid one cycle after rom_addr
//     jump_valid  redirect request, single-cycle pulse
//     jump_addr   redirect target
//     done        walk is past DEPTH and nothing is buffered or in flight
//     instr       instruction stream (valid/ready/data/pc), master side
// ---------------------------------------------------------------------------
module rom_fetch #(
    parameter int WIDTH      = 15,
    parameter int DEPTH      = 1023,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [$clog2(DEPTH):0] rom_addr,
    input  logic [WIDTH:0]         rom_data,
    input  logic                   jump_valid,
    input  logic [$clog2(DEPTH):0] jump_addr,
    output logic                   done,
    rom_fetch_if.master            instr
);

    localparam int AW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [AW:0]   LAST_PC  = (AW + 1)'(DEPTH);
    localparam logic [CW:0]   FULL_OCC = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    // pc carries one extra bit so that stepping past DEPTH is detectable
    // without wrapping back to address 0.
    logic [AW:0]     pc;
    logic            inflight;
    logic [AW-1:0]   inflight_pc;

    logic [AW-1:0]   mem_pc   [FIFO_DEPTH];
    logic [WIDTH:0]  mem_data [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            pop;
    logic            push;
    logic            issue;
    logic            pc_in_range;
    logic [CW:0]     occupancy;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign pop         = instr.instr_valid && instr.instr_ready;
    assign push        = inflight && !jump_valid;
    assign pc_in_range = (pc <= LAST_PC);

    // Slots that will be committed after this edge if we issue nothing now:
    // buffered words plus the word returning from the ROM, minus the word
    // being accepted. Issuing only when this is below FIFO_DEPTH guarantees
    // the returning word always has room, so no backpressure to the ROM.
    assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
    assign issue     = !jump_valid && pc_in_range && (occupancy < FULL_OCC);

    assign rom_addr = pc[AW-1:0];

    // Head outputs are forced to zero when empty so the reset and flush
    // values are defined even though the storage itself is not reset.
    assign instr.instr_valid = (count != '0);
    assign instr.instr_data  = instr.instr_valid ? mem_data[rd_ptr] : '0;
    assign instr.instr_pc    = instr.instr_valid ? mem_pc[rd_ptr]   : '0;

    assign done = !pc_in_range && (count == '0) && !inflight;

    // Control state. A jump outranks everything: it drops buffered words,
    // discards the word returning from the ROM and suppresses issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (jump_valid) begin
            pc       <= {1'b0, jump_addr};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc[AW-1:0];
                pc          <= pc + (AW + 1)'(1);
            end
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Buffer storage, written with the returning ROM word and its address.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_pc[wr_ptr]   <= inflight_pc;
            mem_data[wr_ptr] <= rom_data;
        end
    end

endmodule

// File: tb/tb_rom_fetch.sv
// ---------------------------------------------------------------------------
// tb_rom_fetch
//   Directed bench for rom_fetch. Two instances share one clock:
//     dut    DEPTH=1023 : streaming, backpressure, jump, mid-stream reset
//     dut_s  DEPTH=7    : end of ROM, done, jump back in, jump out of range
//   Each ROM is modelled as a registered read returning address*3.
// ---------------------------------------------------------------------------
module tb_rom_fetch;

    localparam int WIDTH = 15;
    localparam int AW    = 11;
    localparam int AW_S  = 4;

    logic clk;
    int   checks;
    int   failures;

    // Large instance signals
    logic            rst;
    logic [AW-1:0]   rom_addr;
    logic [WIDTH:0]  rom_data;
    logic            jump_valid;
    logic [AW-1:0]   jump_addr;
    logic            done;

    // Small instance signals
    logic            rst_s;
    logic [AW_S-1:0] rom_addr_s;
    logic [WIDTH:0]  rom_data_s;
    logic            jump_valid_s;
    logic [AW_S-1:0] jump_addr_s;
    logic            done_s;

    rom_fetch_if #(.WIDTH(WIDTH), .AW(AW))   bus ();
    rom_fetch_if #(.WIDTH(WIDTH), .AW(AW_S)) bus_s ();

    rom_fetch #(.WIDTH(WIDTH), .DEPTH(1023), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .done       (done),
        .instr      (bus.master)
    );

    rom_fetch #(.WIDTH(WIDTH), .DEPTH(7), .FIFO_DEPTH(2)) dut_s (
        .clk        (clk),
        .rst        (rst_s),
        .rom_addr   (rom_addr_s),
        .rom_data   (rom_data_s),
        .jump_valid (jump_valid_s),
        .jump_addr  (jump_addr_s),
        .done       (done_s),
        .instr      (bus_s.master)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM models: ROM[i] = i*3
    always @(posedge clk) begin
        rom_data   <= {5'b0, rom_addr} * 16'd3;
        rom_data_s <= {12'b0, rom_addr_s} * 16'd3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic rdy,
                                 input logic jv, input logic [AW-1:0] ja);
        rst             = r;
        bus.instr_ready = rdy;
        jump_valid      = jv;
        jump_addr       = ja;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rom_data     = '0;
        rom_data_s   = '0;
        rst_s        = 1'b1;
        jump_valid_s = 1'b0;
        jump_addr_s  = '0;
        bus_s.instr_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, '0);

        // ---- Reset state ----
        tick();
        tick();
        checkOutput("rst_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("rst_done",  32'(done),            32'd0);
        checkOutput("rst_addr",  32'(rom_addr),        32'd0);
        checkOutput("rst_data",  32'(bus.instr_data),  32'd0);
        checkOutput("rst_pc",    32'(bus.instr_pc),    32'd0);

        // ---- Release: first word two edges later, then one per cycle ----
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        tick();
        checkOutput("start_bubble", 32'(bus.instr_valid), 32'd0);
        tick();
        checkOutput("start_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("start_pc",    32'(bus.instr_pc),    32'd0);
        checkOutput("start_data",  32'(bus.instr_data),  32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checkOutput("stream_valid", 32'(bus.instr_valid), 32'd1);
            checkOutput("stream_pc",    32'(bus.instr_pc),    32'(k));
            checkOutput("stream_data",  32'(bus.instr_data),  32'(3 * k));
        end

        // ---- Backpressure: head 5 frozen, FIFO fills, issue stops at pc 7 ----
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("stall_valid", 32'(bus.instr_valid), 32'd1);
            checkOutput("stall_pc",    32'(bus.instr_pc),    32'd5);
            checkOutput("stall_data",  32'(bus.instr_data),  32'd15);
            checkOutput("stall_addr",  32'(rom_addr),        32'd7);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        for (int k = 6; k <= 9; k++) begin
            tick();
            checkOutput("resume_pc",   32'(bus.instr_pc),   32'(k));
            checkOutput("resume_data", 32'(bus.instr_data), 32'(3 * k));
        end

        // ---- Jump to 100 while streaming ----
        applyStimulus(1'b0, 1'b1, 1'b1, 11'd100);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("jump_flush", 32'(bus.instr_valid), 32'd0);
        checkOutput("jump_addr",  32'(rom_addr),        32'd100);
        checkOutput("jump_done",  32'(done),            32'd0);
        tick();
        checkOutput("jump_bubble", 32'(bus.instr_valid), 32'd0);
        tick();
        checkOutput("jump_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("jump_pc",    32'(bus.instr_pc),    32'd100);
        checkOutput("jump_data",  32'(bus.instr_data),  32'd300);
        for (int k = 101; k <= 102; k++) begin
            tick();
            checkOutput("post_jump_pc",   32'(bus.instr_pc),   32'(k));
            checkOutput("post_jump_data", 32'(bus.instr_data), 32'(3 * k));
        end

        // ---- Reset mid-stream with a full FIFO ----
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        tick();
        tick();
        tick();
        checkOutput("full_pc", 32'(bus.instr_pc), 32'd102);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        tick();
        checkOutput("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        checkOutput("mid_rst_pc",    32'(bus.instr_pc),    32'd0);
        checkOutput("mid_rst_data",  32'(bus.instr_data),  32'd0);
        checkOutput("mid_rst_addr",  32'(rom_addr),        32'd0);
        checkOutput("mid_rst_done",  32'(done),            32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        tick();
        checkOutput("restart_bubble", 32'(bus.instr_valid), 32'd0);
        tick();
        checkOutput("restart_valid", 32'(bus.instr_valid), 32'd1);
        checkOutput("restart_pc",    32'(bus.instr_pc),    32'd0);
        tick();
        checkOutput("restart_pc1",   32'(bus.instr_pc),    32'd1);
        checkOutput("restart_data1", 32'(bus.instr_data),  32'd3);

        // ---- Small ROM (DEPTH=7): run to the end ----
        bus_s.instr_ready = 1'b1;
        rst_s = 1'b0;
        tick();
        checkOutput("s_bubble", 32'(bus_s.instr_valid), 32'd0);
        for (int k = 0; k <= 7; k++) begin
            tick();
            checkOutput("s_valid", 32'(bus_s.instr_valid), 32'd1);
            checkOutput("s_pc",    32'(bus_s.instr_pc),    32'(k));
            checkOutput("s_data",  32'(bus_s.instr_data),  32'(3 * k));
            checkOutput("s_done_low", 32'(done_s),         32'd0);
        end
        tick();
        checkOutput("s_end_valid", 32'(bus_s.instr_valid), 32'd0);
        checkOutput("s_end_done",  32'(done_s),            32'd1);
        tick();
        checkOutput("s_end_hold",  32'(done_s),            32'd1);
        checkOutput("s_end_addr",  32'(rom_addr_s),        32'd8);

        // ---- Small ROM: jump back to 2 ----
        jump_valid_s = 1'b1;
        jump_addr_s  = 4'd2;
        tick();
        jump_valid_s = 1'b0;
        checkOutput("s_jmp_done",  32'(done_s),            32'd0);
        checkOutput("s_jmp_valid", 32'(bus_s.instr_valid), 32'd0);
        tick();
        tick();
        checkOutput("s_jmp_pc",    32'(bus_s.instr_pc),    32'd2);
        checkOutput("s_jmp_data",  32'(bus_s.instr_data),  32'd6);

        // ---- Small ROM: jump out of range ----
        jump_valid_s = 1'b1;
        jump_addr_s  = 4'd9;
        tick();
        jump_valid_s = 1'b0;
        checkOutput("s_oor_valid", 32'(bus_s.instr_valid), 32'd0);
        checkOutput("s_oor_done",  32'(done_s),            32'd1);
        tick();
        checkOutput("s_oor_valid2", 32'(bus_s.instr_valid), 32'd0);
        checkOutput("s_oor_done2",  32'(done_s),            32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
